csr_access_sequencer: RTL and testbench

//  Owns the single read/write port of the machine-mode CSR file. Arbitrates it between the pipeline's Zicsr instruction (RMW), trap entry and MRET.

---
 rtl/csr_access_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer
// Owns the single read/write port of the machine-mode CSR file and shares it
// between Zicsr read-modify-write instructions, trap entry and MRET. Trap entry
// and MRET touch several CSRs, so they are walked one register per cycle while
// the pipeline is held. Write data leaves unmasked; a masking stage sits
// between o_file_wdata and the CSR file.
module csr_access_sequencer #(
    parameter  logic [1:0] XLEN = 2'd2,                   // 2'd1: 32-bit, 2'd2: 64-bit
    localparam int         W    = 1 << (int'(XLEN) + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    // Zicsr instruction
    input  logic          i_csr_req,
    input  logic [11:0]   i_csr_addr,
    input  logic [2:0]    i_csr_funct3,
    input  logic [W-1:0]  i_csr_operand,
    input  logic          i_csr_src_zero,
    output logic          o_csr_ack,
    output logic [W-1:0]  o_csr_rdata,
    output logic          o_csr_illegal,
    // trap entry
    input  logic          i_trap_req,
    input  logic [W-1:0]  i_trap_cause,
    input  logic [W-1:0]  i_trap_pc,
    input  logic [W-1:0]  i_trap_tval,
    output logic          o_trap_done,
    // MRET
    input  logic          i_mret_req,
    output logic          o_mret_done,
    output logic [W-1:0]  o_redirect_pc,
    // CSR file port
    output logic [11:0]   o_file_addr,
    output logic          o_file_we,
    output logic [W-1:0]  o_file_wdata,
    input  logic [W-1:0]  i_file_rdata,
    // pipeline hold
    output logic          o_stall
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_C_RW      = 4'd1;
    localparam logic [3:0] S_C_DONE    = 4'd2;
    localparam logic [3:0] S_T_MEPC    = 4'd3;
    localparam logic [3:0] S_T_MCAUSE  = 4'd4;
    localparam logic [3:0] S_T_MTVAL   = 4'd5;
    localparam logic [3:0] S_T_MTVEC   = 4'd6;
    localparam logic [3:0] S_T_MSTATUS = 4'd7;
    localparam logic [3:0] S_T_DONE    = 4'd8;
    localparam logic [3:0] S_R_MEPC    = 4'd9;
    localparam logic [3:0] S_R_MSTATUS = 4'd10;
    localparam logic [3:0] S_R_DONE    = 4'd11;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    // funct3[1:0]; funct3[2] only selects register vs immediate source
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode as previous
    function automatic logic [W-1:0] trap_mstatus(input logic [W-1:0] s);
        logic [W-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // MRET: restore MIE from MPIE, set MPIE, previous mode stays M
    function automatic logic [W-1:0] mret_mstatus(input logic [W-1:0] s);
        logic [W-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    logic [3:0]   state_q, state_d;
    logic [11:0]  addr_q, addr_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] operand_q, operand_d;
    logic         src_zero_q, src_zero_d;
    logic [W-1:0] cause_q, cause_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] tval_q, tval_d;
    logic [W-1:0] old_q, old_d;
    logic         illegal_q, illegal_d;
    logic [W-1:0] redirect_q, redirect_d;

    logic         csr_ro;
    logic         csr_pending;
    logic [W-1:0] csr_new;

    // The immediate-form bit and the PC's low bits never influence the result
    logic unused_inputs;
    assign unused_inputs = ^{i_csr_funct3[2], i_trap_pc[1:0]};

    // Zicsr new-value and write-intent decode for the captured instruction
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        csr_ro      = (addr_q[11:10] == 2'b11);
        csr_pending = 1'b0;
        csr_new     = i_file_rdata;
        case (op_q)
            OP_RW: begin
                csr_pending = 1'b1;
                csr_new     = operand_q;
            end
            OP_RS: begin
                csr_pending = !src_zero_q;
                csr_new     = i_file_rdata | operand_q;
            end
            OP_RC: begin
                csr_pending = !src_zero_q;
                csr_new     = i_file_rdata & ~operand_q;
            end
            default: ;
        endcase
    end

    // Arbitration, sequencing and CSR file port drive
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        op_d         = op_q;
        operand_d    = operand_q;
        src_zero_d   = src_zero_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        tval_d       = tval_q;
        old_d        = old_q;
        illegal_d    = illegal_q;
        redirect_d   = redirect_q;
        o_file_addr  = 12'h000;
        o_file_we    = 1'b0;
        o_file_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (i_trap_req) begin
                    state_d = S_T_MEPC;
                    cause_d = i_trap_cause;
                    pc_d    = {i_trap_pc[W-1:2], 2'b00};
                    tval_d  = i_trap_tval;
                end else if (i_mret_req) begin
                    state_d = S_R_MEPC;
                end else if (i_csr_req) begin
                    state_d    = S_C_RW;
                    addr_d     = i_csr_addr;
                    op_d       = i_csr_funct3[1:0];
                    operand_d  = i_csr_operand;
                    src_zero_d = i_csr_src_zero;
                end
            end
            S_C_RW: begin
                o_file_addr  = addr_q;
                o_file_we    = csr_pending && !csr_ro;
                o_file_wdata = csr_new;
                old_d        = i_file_rdata;
                illegal_d    = csr_pending && csr_ro;
                state_d      = S_C_DONE;
            end
            S_T_MEPC: begin
                o_file_addr  = ADDR_MEPC;
                o_file_we    = 1'b1;
                o_file_wdata = pc_q;
                state_d      = S_T_MCAUSE;
            end
            S_T_MCAUSE: begin
                o_file_addr  = ADDR_MCAUSE;
                o_file_we    = 1'b1;
                o_file_wdata = cause_q;
                state_d      = S_T_MTVAL;
            end
            S_T_MTVAL: begin
                o_file_addr  = ADDR_MTVAL;
                o_file_we    = 1'b1;
                o_file_wdata = tval_q;
                state_d      = S_T_MTVEC;
            end
            S_T_MTVEC: begin
                // Only exceptions reach here, so vectored mode never applies
                o_file_addr = ADDR_MTVEC;
                redirect_d  = {i_file_rdata[W-1:2], 2'b00};
                state_d     = S_T_MSTATUS;
            end
            S_T_MSTATUS: begin
                o_file_addr  = ADDR_MSTATUS;
                o_file_we    = 1'b1;
                o_file_wdata = trap_mstatus(i_file_rdata);
                state_d      = S_T_DONE;
            end
            S_R_MEPC: begin
                o_file_addr = ADDR_MEPC;
                redirect_d  = i_file_rdata;
                state_d     = S_R_MSTATUS;
            end
            S_R_MSTATUS: begin
                o_file_addr  = ADDR_MSTATUS;
                o_file_we    = 1'b1;
                o_file_wdata = mret_mstatus(i_file_rdata);
                state_d      = S_R_DONE;
            end
            S_C_DONE, S_T_DONE, S_R_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completion pulses and results, decoded from state so reset clears them at once
    assign o_stall       = (state_q != S_IDLE);
    assign o_csr_ack     = (state_q == S_C_DONE);
    assign o_csr_rdata   = (state_q == S_C_DONE) ? old_q : '0;
    assign o_csr_illegal = (state_q == S_C_DONE) && illegal_q;
    assign o_trap_done   = (state_q == S_T_DONE);
    assign o_mret_done   = (state_q == S_R_DONE);
    assign o_redirect_pc = ((state_q == S_T_DONE) || (state_q == S_R_DONE)) ? redirect_q : '0;

    // State and captured-request registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values of the others, regardless of statement order.
        if (i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 12'h000;
            op_q       <= 2'b00;
            operand_q  <= '0;
            src_zero_q <= 1'b0;
            cause_q    <= '0;
            pc_q       <= '0;
            tval_q     <= '0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            src_zero_q <= src_zero_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            tval_q     <= tval_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
            redirect_q <= redirect_d;
        end
    end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Self-checking bench for csr_access_sequencer: a behavioural CSR file plus a
// reference model that applies each request's architectural effect directly.
module tb_csr_access_sequencer;

    localparam int W = 64;

    typedef struct packed {
        logic [11:0]  addr;
        logic [W-1:0] data;
    } wr_t;

    localparam logic [11:0] ADDR_TBL [9] = '{12'h340, 12'h300, 12'h341, 12'h342, 12'h343,
                                              12'h305, 12'hC00, 12'hF14, 12'h7C0};

    logic          i_clk;
    logic          i_rst;
    logic          i_csr_req;
    logic [11:0]   i_csr_addr;
    logic [2:0]    i_csr_funct3;
    logic [W-1:0]  i_csr_operand;
    logic          i_csr_src_zero;
    logic          o_csr_ack;
    logic [W-1:0]  o_csr_rdata;
    logic          o_csr_illegal;
    logic          i_trap_req;
    logic [W-1:0]  i_trap_cause;
    logic [W-1:0]  i_trap_pc;
    logic [W-1:0]  i_trap_tval;
    logic          o_trap_done;
    logic          i_mret_req;
    logic          o_mret_done;
    logic [W-1:0]  o_redirect_pc;
    logic [11:0]   o_file_addr;
    logic          o_file_we;
    logic [W-1:0]  o_file_wdata;
    logic [W-1:0]  i_file_rdata;
    logic          o_stall;

    int checks = 0;
    int errors = 0;

    csr_access_sequencer #(.XLEN(2'd2)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_csr_req      (i_csr_req),
        .i_csr_addr     (i_csr_addr),
        .i_csr_funct3   (i_csr_funct3),
        .i_csr_operand  (i_csr_operand),
        .i_csr_src_zero (i_csr_src_zero),
        .o_csr_ack      (o_csr_ack),
        .o_csr_rdata    (o_csr_rdata),
        .o_csr_illegal  (o_csr_illegal),
        .i_trap_req     (i_trap_req),
        .i_trap_cause   (i_trap_cause),
        .i_trap_pc      (i_trap_pc),
        .i_trap_tval    (i_trap_tval),
        .o_trap_done    (o_trap_done),
        .i_mret_req     (i_mret_req),
        .o_mret_done    (o_mret_done),
        .o_redirect_pc  (o_redirect_pc),
        .o_file_addr    (o_file_addr),
        .o_file_we      (o_file_we),
        .o_file_wdata   (o_file_wdata),
        .i_file_rdata   (i_file_rdata),
        .o_stall        (o_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural CSR file with a write log; backdoor port presets contents
    logic [W-1:0] csr_mem [0:4095];
    logic         bd_clear;
    logic         bd_we;
    logic [11:0]  bd_addr;
    logic [W-1:0] bd_data;
    int           wr_cnt;
    logic [11:0]  wr_addr_log [0:1023];
    logic [W-1:0] wr_data_log [0:1023];

    assign i_file_rdata = csr_mem[o_file_addr];

    always @(posedge i_clk) begin
        if (bd_clear) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
            wr_cnt <= 0;
        end else begin
            if (o_file_we) begin
                csr_mem[o_file_addr] <= o_file_wdata;
                if (wr_cnt < 1024) begin
                    wr_addr_log[wr_cnt] <= o_file_addr;
                    wr_data_log[wr_cnt] <= o_file_wdata;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (bd_we) csr_mem[bd_addr] <= bd_data;
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] model_csr [logic [11:0]];
    wr_t          exp_q [$];

    function automatic logic [W-1:0] mread(input logic [11:0] a);
        return model_csr.exists(a) ? model_csr[a] : '0;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        model_csr[a] = d;
        exp_q.push_back(w);
    endtask

    task automatic model_csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [W-1:0] opnd,
                                input bit sz, output logic [W-1:0] old, output bit illegal);
        bit           wants;
        bit           read_only;
        logic [W-1:0] nv;
        old = mread(a);
        wants = 1'b0;
        nv = old;
        case (f3[1:0])
            2'b01: begin wants = 1'b1; nv = opnd;        end
            2'b10: begin wants = !sz;  nv = old | opnd;  end
            2'b11: begin wants = !sz;  nv = old & ~opnd; end
            default: ;
        endcase
        read_only = (a[11:10] == 2'b11);
        illegal = wants && read_only;
        if (wants && !read_only) model_write(a, nv);
    endtask

    task automatic model_trap(input logic [W-1:0] cause, input logic [W-1:0] pc, input logic [W-1:0] tval,
                              output logic [W-1:0] redirect);
        logic [W-1:0] st, ns;
        st = mread(12'h300);
        model_write(12'h341, pc & ~64'h3);
        model_write(12'h342, cause);
        model_write(12'h343, tval);
        redirect = mread(12'h305) & ~64'h3;
        ns = st;
        ns[7] = st[3];
        ns[3] = 1'b0;
        ns[12:11] = 2'b11;
        model_write(12'h300, ns);
    endtask

    task automatic model_mret(output logic [W-1:0] redirect);
        logic [W-1:0] st, ns;
        redirect = mread(12'h341);
        st = mread(12'h300);
        ns = st;
        ns[3] = st[7];
        ns[7] = 1'b1;
        ns[12:11] = 2'b11;
        model_write(12'h300, ns);
    endtask

    task automatic poke(input logic [11:0] a, input logic [W-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge i_clk); #1;
        bd_we   = 1'b0;
        model_csr[a] = d;
    endtask

    // ---------------- transactions ----------------
    task automatic csr_txn(input logic [11:0] a, input logic [2:0] f3, input logic [W-1:0] opnd,
                           input bit sz, input string name);
        logic [W-1:0] exp_old, got_rdata;
        bit           exp_ill;
        logic         got_ill;
        int           start, cycles;
        bit           got;
        exp_q.delete();
        model_csr_op(a, f3, opnd, sz, exp_old, exp_ill);
        start = wr_cnt;
        i_csr_addr = a; i_csr_funct3 = f3; i_csr_operand = opnd; i_csr_src_zero = sz;
        i_csr_req = 1'b1;
        cycles = 0; got = 1'b0; got_rdata = '0; got_ill = 1'b0;
        while (!got && cycles < 20) begin
            @(posedge i_clk); #1; cycles++;
            if (o_csr_ack) begin
                got = 1'b1; got_rdata = o_csr_rdata; got_ill = o_csr_illegal;
                i_csr_req = 1'b0;
            end
        end
        i_csr_req = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s ack_timeout: no o_csr_ack within 20 cycles", name);
        end else begin
            checks++;
            if (cycles !== 2) begin errors++; $display("FAIL %s ack_latency: got %0d expected 2", name, cycles); end
            checks++;
            if (got_rdata !== exp_old) begin errors++; $display("FAIL %s rdata: got %h expected %h", name, got_rdata, exp_old); end
            checks++;
            if (got_ill !== exp_ill) begin errors++; $display("FAIL %s illegal: got %b expected %b", name, got_ill, exp_ill); end
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_csr_ack !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL %s ack_pulse: ack=%b stall=%b expected 0 0", name, o_csr_ack, o_stall);
        end
        checks++;
        if (wr_cnt - start !== exp_q.size()) begin
            errors++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_cnt - start, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (wr_addr_log[start+i] !== exp_q[i].addr || wr_data_log[start+i] !== exp_q[i].data) begin
                    errors++; $display("FAIL %s write%0d: got %h=%h expected %h=%h", name, i,
                        wr_addr_log[start+i], wr_data_log[start+i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic seq_txn(input bit is_trap, input logic [W-1:0] cause, input logic [W-1:0] pc,
                           input logic [W-1:0] tval, input string name);
        logic [W-1:0] exp_redir, got_redir;
        int           start, cycles, stalls, exp_lat;
        bit           got;
        exp_q.delete();
        if (is_trap) model_trap(cause, pc, tval, exp_redir);
        else         model_mret(exp_redir);
        exp_lat = is_trap ? 6 : 3;
        start = wr_cnt;
        i_trap_cause = cause; i_trap_pc = pc; i_trap_tval = tval;
        if (is_trap) i_trap_req = 1'b1; else i_mret_req = 1'b1;
        cycles = 0; stalls = 0; got = 1'b0; got_redir = '0;
        while (!got && cycles < 30) begin
            @(posedge i_clk); #1; cycles++;
            if (o_stall) stalls++;
            if (is_trap ? o_trap_done : o_mret_done) begin
                got = 1'b1; got_redir = o_redirect_pc;
                i_trap_req = 1'b0; i_mret_req = 1'b0;
            end
        end
        i_trap_req = 1'b0; i_mret_req = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s done_timeout: no done pulse within 30 cycles", name);
        end else begin
            checks++;
            if (cycles !== exp_lat) begin errors++; $display("FAIL %s done_latency: got %0d expected %0d", name, cycles, exp_lat); end
            checks++;
            if (stalls !== exp_lat) begin errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat); end
            checks++;
            if (got_redir !== exp_redir) begin errors++; $display("FAIL %s redirect: got %h expected %h", name, got_redir, exp_redir); end
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_trap_done !== 1'b0 || o_mret_done !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: trap_done=%b mret_done=%b stall=%b expected 0 0 0",
                               name, o_trap_done, o_mret_done, o_stall);
        end
        checks++;
        if (wr_cnt - start !== exp_q.size()) begin
            errors++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_cnt - start, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (wr_addr_log[start+i] !== exp_q[i].addr || wr_data_log[start+i] !== exp_q[i].data) begin
                    errors++; $display("FAIL %s write%0d: got %h=%h expected %h=%h", name, i,
                        wr_addr_log[start+i], wr_data_log[start+i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_csr_ack, o_csr_rdata, o_csr_illegal, o_trap_done, o_mret_done, o_redirect_pc,
             o_file_addr, o_file_we, o_file_wdata, o_stall} !== '0) begin
            errors++; $display("FAIL reset_outputs: got stall=%b we=%b addr=%h expected all zero", o_stall, o_file_we, o_file_addr);
        end
        i_rst = 1'b0;
        bd_clear = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_stall !== 1'b0 || o_file_we !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: stall=%b we=%b expected 0 0", o_stall, o_file_we);
        end
    endtask

    task automatic test_csr_rw();
        poke(12'h340, 64'h1234);
        csr_txn(12'h340, 3'b001, 64'hDEADBEEF, 1'b0, "csrrw_mscratch");
        csr_txn(12'h340, 3'b011, 64'h0000FFFF, 1'b0, "csrrc_mscratch");
        csr_txn(12'h340, 3'b110, 64'h5, 1'b0, "csrrsi_mscratch");
    endtask

    task automatic test_csr_src_zero();
        poke(12'h300, 64'h8);
        csr_txn(12'h300, 3'b010, 64'h0, 1'b1, "csrrs_zero_mstatus");
        csr_txn(12'h300, 3'b111, 64'h0, 1'b1, "csrrci_zero_mstatus");
    endtask

    task automatic test_csr_illegal();
        poke(12'hC00, 64'h77);
        csr_txn(12'hC00, 3'b001, 64'h5, 1'b0, "csrrw_readonly");
        csr_txn(12'hC00, 3'b010, 64'h0, 1'b1, "csrrs_readonly_read");
    endtask

    task automatic test_trap();
        poke(12'h300, 64'h8);
        poke(12'h305, 64'h80000101);
        seq_txn(1'b1, 64'h2, 64'h80000013, 64'h13, "trap_basic");
        checks++;
        if (csr_mem[12'h300] !== 64'h1880 || csr_mem[12'h341] !== 64'h80000010) begin
            errors++; $display("FAIL trap_file: mstatus=%h mepc=%h expected 1880 80000010", csr_mem[12'h300], csr_mem[12'h341]);
        end
    endtask

    task automatic test_mret();
        poke(12'h341, 64'h80000040);
        poke(12'h300, 64'h1880);
        seq_txn(1'b0, '0, '0, '0, "mret_basic");
        checks++;
        if (csr_mem[12'h300] !== 64'h1888) begin
            errors++; $display("FAIL mret_file: mstatus=%h expected 1888", csr_mem[12'h300]);
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] trap_redir, mret_redir, exp_old;
        bit           exp_ill;
        int           order [$];
        int           start, cycles;
        exp_q.delete();
        model_trap(64'h5, 64'h80000200, 64'hABC, trap_redir);
        model_mret(mret_redir);
        model_csr_op(12'h340, 3'b010, 64'hF0, 1'b0, exp_old, exp_ill);
        start = wr_cnt;
        i_trap_cause = 64'h5; i_trap_pc = 64'h80000200; i_trap_tval = 64'hABC;
        i_csr_addr = 12'h340; i_csr_funct3 = 3'b010; i_csr_operand = 64'hF0; i_csr_src_zero = 1'b0;
        i_trap_req = 1'b1; i_mret_req = 1'b1; i_csr_req = 1'b1;
        cycles = 0;
        while (order.size() < 3 && cycles < 40) begin
            @(posedge i_clk); #1; cycles++;
            if (o_trap_done) begin
                order.push_back(1); i_trap_req = 1'b0;
                checks++;
                if (o_redirect_pc !== trap_redir) begin errors++; $display("FAIL prio_trap_redirect: got %h expected %h", o_redirect_pc, trap_redir); end
            end
            if (o_mret_done) begin
                order.push_back(2); i_mret_req = 1'b0;
                checks++;
                if (o_redirect_pc !== mret_redir) begin errors++; $display("FAIL prio_mret_redirect: got %h expected %h", o_redirect_pc, mret_redir); end
            end
            if (o_csr_ack) begin
                order.push_back(3); i_csr_req = 1'b0;
                checks++;
                if (o_csr_rdata !== exp_old) begin errors++; $display("FAIL prio_csr_rdata: got %h expected %h", o_csr_rdata, exp_old); end
            end
        end
        i_trap_req = 1'b0; i_mret_req = 1'b0; i_csr_req = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (order.size() !== 3 || order[0] !== 1 || order[1] !== 2 || order[2] !== 3) begin
            errors++; $display("FAIL prio_order: got %p expected '{1, 2, 3} (trap, mret, csr)", order);
        end
        checks++;
        if (wr_cnt - start !== exp_q.size()) begin
            errors++; $display("FAIL prio_write_count: got %0d expected %0d", wr_cnt - start, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (wr_addr_log[start+i] !== exp_q[i].addr || wr_data_log[start+i] !== exp_q[i].data) begin
                    errors++; $display("FAIL prio_write%0d: got %h=%h expected %h=%h", i,
                        wr_addr_log[start+i], wr_data_log[start+i], exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        int start;
        poke(12'h343, 64'hAAAA);
        poke(12'h300, 64'h8);
        poke(12'h305, 64'h100);
        exp_q.delete();
        model_write(12'h341, 64'h80000300);
        start = wr_cnt;
        i_trap_cause = 64'h7; i_trap_pc = 64'h80000302; i_trap_tval = 64'h55;
        i_trap_req = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_csr_ack, o_csr_rdata, o_csr_illegal, o_trap_done, o_mret_done, o_redirect_pc,
             o_file_addr, o_file_we, o_file_wdata, o_stall} !== '0) begin
            errors++; $display("FAIL midreset_outputs: stall=%b we=%b addr=%h expected all zero", o_stall, o_file_we, o_file_addr);
        end
        @(posedge i_clk); #1;
        i_trap_req = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (wr_cnt - start !== 1 || wr_addr_log[start] !== exp_q[0].addr || wr_data_log[start] !== exp_q[0].data) begin
            errors++; $display("FAIL midreset_writes: got %0d writes first %h=%h expected 1 write %h=%h",
                wr_cnt - start, wr_addr_log[start], wr_data_log[start], exp_q[0].addr, exp_q[0].data);
        end
        checks++;
        if (csr_mem[12'h343] !== mread(12'h343) || csr_mem[12'h300] !== mread(12'h300)) begin
            errors++; $display("FAIL midreset_untouched: mtval=%h mstatus=%h expected %h %h",
                csr_mem[12'h343], csr_mem[12'h300], mread(12'h343), mread(12'h300));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                seq_txn(1'b1, {32'h0, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "rand_trap");
            end else if (kind == 1) begin
                seq_txn(1'b0, '0, '0, '0, "rand_mret");
            end else begin
                logic [11:0]  a;
                logic [2:0]   f3;
                logic [W-1:0] opnd;
                bit           sz;
                a  = ADDR_TBL[$urandom_range(0, 8)];
                f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
                if (f3[2]) begin
                    opnd = W'($urandom_range(0, 31));
                    sz   = (opnd == '0);
                end else begin
                    sz   = ($urandom_range(0, 3) == 0);
                    opnd = sz ? '0 : {$urandom, $urandom};
                end
                csr_txn(a, f3, opnd, sz, "rand_csr");
            end
        end
    endtask

    task automatic test_file_contents();
        foreach (ADDR_TBL[i]) begin
            checks++;
            if (csr_mem[ADDR_TBL[i]] !== mread(ADDR_TBL[i])) begin
                errors++; $display("FAIL file_%h: got %h expected %h", ADDR_TBL[i], csr_mem[ADDR_TBL[i]], mread(ADDR_TBL[i]));
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; bd_clear = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        i_csr_req = 1'b0; i_csr_addr = '0; i_csr_funct3 = '0; i_csr_operand = '0; i_csr_src_zero = 1'b0;
        i_trap_req = 1'b0; i_trap_cause = '0; i_trap_pc = '0; i_trap_tval = '0; i_mret_req = 1'b0;
        test_reset();
        test_csr_rw();
        test_csr_src_zero();
        test_csr_illegal();
        test_trap();
        test_mret();
        test_priority();
        test_reset_mid_trap();
        test_random();
        test_file_contents();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
